// File: rtl/instr_assembler_pkg.sv
// Shared types and immediate range helpers for the RV32I/Zicsr instruction assembler.
package instr_assembler_pkg;

  typedef logic [31:0] instr_t;

  typedef enum logic [2:0] {
    R_TYPE     = 3'd0,
    I_TYPE     = 3'd1,
    S_TYPE     = 3'd2,
    B_TYPE     = 3'd3,
    U_TYPE     = 3'd4,
    J_TYPE     = 3'd5,
    CSR_I_TYPE = 3'd6
  } instr_format_t;

  // True when imm[31:lsb] are all equal, i.e. the value survives sign extension from bit lsb.
  function automatic logic fitsSigned(input logic [31:0] imm, input int unsigned lsb);
    logic [31:0] upper;
    upper = $signed(imm) >>> lsb;
    return (upper == '0) || (upper == '1);
  endfunction

  function automatic logic fitsUimm5(input logic [31:0] imm);
    return imm[31:5] == '0;
  endfunction

endpackage

// File: rtl/instr_assembler_if.sv
// Request/response bus of the instruction assembler, including its control and sticky status lines.
interface instr_assembler_if #(
  parameter int ADDR_WIDTH = 10
) ();
  import instr_assembler_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  instr_format_t         in_format;
  logic [6:0]            in_opcode;
  logic [4:0]            in_rd;
  logic [2:0]            in_funct3;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [6:0]            in_funct7;
  logic [31:0]           in_imm;
  logic                  out_valid;
  logic                  out_ready;
  instr_t                out_instr;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  restart;
  logic                  imm_err;
  logic                  wrapped;

  modport master (
    output in_valid, in_format, in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_funct7, in_imm,
    output out_ready, restart,
    input  in_ready, out_valid, out_instr, out_addr, imm_err, wrapped
  );

  modport slave (
    input  in_valid, in_format, in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_funct7, in_imm,
    input  out_ready, restart,
    output in_ready, out_valid, out_instr, out_addr, imm_err, wrapped
  );

endinterface

// File: rtl/instr_assembler_immenc.sv
// Combinational packer: scatters the immediate into the selected instruction format and flags
// immediates that the format cannot represent.
module instr_assembler_immenc
  import instr_assembler_pkg::*;
(
  input  instr_format_t format_i,
  input  logic [6:0]    opcode_i,
  input  logic [4:0]    rd_i,
  input  logic [2:0]    funct3_i,
  input  logic [4:0]    rs1_i,
  input  logic [4:0]    rs2_i,
  input  logic [6:0]    funct7_i,
  input  logic [31:0]   imm_i,
  output instr_t        instr_o,
  output logic          legal_o
);

  always_comb begin
    instr_o = '0;
    legal_o = 1'b0;
    unique case (format_i)
      R_TYPE: begin
        instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        legal_o = 1'b1;
      end
      I_TYPE: begin
        instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        legal_o = fitsSigned(imm_i, 11);
      end
      S_TYPE: begin
        instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        legal_o = fitsSigned(imm_i, 11);
      end
      B_TYPE: begin
        instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], opcode_i};
        legal_o = !imm_i[0] && fitsSigned(imm_i, 12);
      end
      U_TYPE: begin
        instr_o = {imm_i[31:12], rd_i, opcode_i};
        legal_o = imm_i[11:0] == '0;
      end
      J_TYPE: begin
        instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        legal_o = !imm_i[0] && fitsSigned(imm_i, 20);
      end
      // The 12-bit CSR address rides on the funct7/rs2 ports; the immediate is the 5-bit uimm.
      CSR_I_TYPE: begin
        instr_o = {funct7_i, rs2_i, imm_i[4:0], funct3_i, rd_i, opcode_i};
        legal_o = fitsUimm5(imm_i);
      end
      default: begin
        instr_o = '0;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_assembler.sv
// Instruction assembler: accepts field requests, drops unencodable immediates, and emits
// packed words with sequential word addresses through a single output register.
module instr_assembler
  import instr_assembler_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  instr_assembler_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);

  logic                  outValid_q, outValid_d;
  instr_t                outInstr_q, outInstr_d;
  logic [ADDR_WIDTH-1:0] outAddr_q, outAddr_d;
  logic [ADDR_WIDTH-1:0] counter_q, counter_d;
  logic                  immErr_q, immErr_d;
  logic                  wrapped_q, wrapped_d;

  logic   inReady;
  logic   accept;
  instr_t encInstr;
  logic   encLegal;

  instr_assembler_immenc u_immenc (
    .format_i (bus.in_format),
    .opcode_i (bus.in_opcode),
    .rd_i     (bus.in_rd),
    .funct3_i (bus.in_funct3),
    .rs1_i    (bus.in_rs1),
    .rs2_i    (bus.in_rs2),
    .funct7_i (bus.in_funct7),
    .imm_i    (bus.in_imm),
    .instr_o  (encInstr),
    .legal_o  (encLegal)
  );

  assign inReady = !bus.restart && (!outValid_q || bus.out_ready);
  assign accept  = bus.in_valid && inReady;

  // A drained output slot may be refilled in the same cycle; restart only touches counter and flags.
  always_comb begin
    outValid_d = outValid_q;
    outInstr_d = outInstr_q;
    outAddr_d  = outAddr_q;
    counter_d  = counter_q;
    immErr_d   = immErr_q;
    wrapped_d  = wrapped_q;

    if (outValid_q && bus.out_ready) begin
      outValid_d = 1'b0;
    end

    if (bus.restart) begin
      counter_d = BaseAddr;
      immErr_d  = 1'b0;
      wrapped_d = 1'b0;
    end else if (accept) begin
      if (encLegal) begin
        outValid_d = 1'b1;
        outInstr_d = encInstr;
        outAddr_d  = counter_q;
        counter_d  = counter_q + 1'b1;
        if (counter_q == '1) begin
          wrapped_d = 1'b1;
        end
      end else begin
        immErr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q <= 1'b0;
      outInstr_q <= '0;
      outAddr_q  <= '0;
      counter_q  <= BaseAddr;
      immErr_q   <= 1'b0;
      wrapped_q  <= 1'b0;
    end else begin
      outValid_q <= outValid_d;
      outInstr_q <= outInstr_d;
      outAddr_q  <= outAddr_d;
      counter_q  <= counter_d;
      immErr_q   <= immErr_d;
      wrapped_q  <= wrapped_d;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid_q;
  assign bus.out_instr = outInstr_q;
  assign bus.out_addr  = outAddr_q;
  assign bus.imm_err   = immErr_q;
  assign bus.wrapped   = wrapped_q;

endmodule

// File: doc/instr_assembler.md
# instr_assembler

Inverse of the decode-side immediate extraction: accepts instruction fields plus a 32-bit immediate over a valid/ready handshake, range-checks the immediate for the selected format, and packs it into a 32-bit RV32I/Zicsr instruction word. Each encoded word is emitted with a sequential word address for writing into instruction memory. Used by the boot loader and test-program injection path ahead of the instruction memory write port.

## Interface
- ADDR_WIDTH, 10, width of word address counter
- BASE_ADDR, 0, counter value after reset/restart
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- restart  in  1  synchronous: counter to BASE_ADDR, clear sticky flags
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_format  in  instr_format_t  format select (R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE, CSR_I_TYPE)
- in_opcode  in  7  opcode, instr[6:0]
- in_rd  in  5  instr[11:7] where format has rd
- in_funct3  in  3  instr[14:12]
- in_rs1  in  5  instr[19:15] (not CSR_I_TYPE)
- in_rs2  in  5  instr[24:20]; CSR address low bits for CSR_I_TYPE
- in_funct7  in  7  instr[31:25]; CSR address high bits for CSR_I_TYPE
- in_imm  in  32  immediate, two's complement (uimm for CSR_I_TYPE)
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts
- out_instr  out  instr_t  encoded instruction
- out_addr  out  ADDR_WIDTH  word address for out_instr
- imm_err  out  1  sticky: an unrepresentable immediate was dropped
- wrapped  out  1  sticky: address counter wrapped

## Operation
- Encoding (fields not listed come from in_* ports):
  - R_TYPE: in_imm ignored, never errors.
  - I_TYPE: [31:20]=imm[11:0]; legal iff imm[31:11] all equal.
  - S_TYPE: [31:25]=imm[11:5], [11:7]=imm[4:0]; legal iff imm[31:11] all equal.
  - B_TYPE: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]; legal iff imm[0]=0 and imm[31:12] all equal.
  - U_TYPE: [31:12]=imm[31:12]; legal iff imm[11:0]=0.
  - J_TYPE: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]; legal iff imm[0]=0 and imm[31:20] all equal.
  - CSR_I_TYPE: [31:20]={in_funct7,in_rs2}, [19:15]=imm[4:0]; legal iff imm[31:5]=0.
  - Other encodings of in_format: treated as illegal.
- Accepted legal request: loaded into output register with current counter as out_addr; counter += 1 (mod 2^ADDR_WIDTH).
- Accepted illegal request: discarded, imm_err set, counter unchanged, output register unchanged.
- Counter at 2^ADDR_WIDTH-1 on a legal accept: wraps to 0, wrapped set.
- restart: in_ready forced low that cycle (restart wins over in_valid); counter to BASE_ADDR, imm_err and wrapped cleared; a pending out_valid word is not affected.

## Timing
- Reset values: out_valid=0, out_instr=0, out_addr=0 (counter=BASE_ADDR), imm_err=0, wrapped=0.
- in_ready = !restart && (!out_valid || out_ready) — combinational, full throughput.
- Latency 1 cycle: legal accept at cycle N gives out_valid at N+1.
- out_instr/out_addr held stable while out_valid && !out_ready.
- Simultaneous output handshake and legal accept: output register reloads, out_valid stays 1.
- imm_err/wrapped visible the cycle after the causing accept.
- rst asserted mid-operation: all state to reset values immediately; pending word lost.

## Structure
- instr_t, instr_format_t in package types; add format legality-check helper functions there.
- Sub-module immenc: combinational field packer + legality check (format, fields, imm -> instr, legal); instr_assembler adds handshake, output register, counter, flags.

## Test plan
- I_TYPE opcode 0x13, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF -> out_instr 0xFFF00093, out_addr 0.
- B_TYPE opcode 0x63, rs1=rs2=0, imm=-4 -> 0xFE000EE3; J_TYPE opcode 0x6F, rd=1, imm=2048 -> 0x001000EF, addresses 0,1.
- B_TYPE imm=3, then I_TYPE imm=2048 -> no out_valid, imm_err=1 next cycle, counter unchanged; restart -> imm_err=0.
- U_TYPE opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7; imm=0x12345001 -> dropped, imm_err=1.
- out_ready low 3 cycles with two queued requests -> in_ready low, out_instr stable, second word emitted after release, addresses 0,1.
- ADDR_WIDTH=2, five legal requests -> out_addr 0,1,2,3,0, wrapped=1; rst mid-stream -> all outputs 0 same cycle.
